load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the RV32 pipeline. Consumes the decoder's memory control fields (`MemReWr`, `MemWHB`) with the ALU-computed address and rs2 data. Drives a word-addressed data-memory request/grant/response port with byte enables, and returns sign- or zero-extended load data. Holds the pipeline through a stall output until the access completes, is rejected as misaligned, or times out.

## Interface
- `TIMEOUT_CYC`, default 255: maximum cycles spent in REQ plus RESP before the access is abandoned with `bus_err`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM stage holds a valid instruction.
- `mem_rw` in 2: `MNONE`/`READ`/`WRITE` encoding from `parameter_define.sv`.
- `mem_whb` in 3: `WORD`/`HALF`/`BYTE`/`HALFU`/`BYTEU` encoding.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `stall` out 1: freeze upstream stages.
- `done` out 1: one-cycle pulse when the access completes.
- `rd_data` out 32: extended load result, registered.
- `misalign` out 1: one-cycle pulse on a rejected access.
- `bus_err` out 1: one-cycle pulse on timeout.
- `dm_req` out 1: memory request.
- `dm_addr` out 32: `{addr[31:2],2'b00}`.
- `dm_we` out 4: byte write enables; 0 for reads.
- `dm_wdata` out 32: lane-steered store data.
- `dm_gnt` in 1: request accepted.
- `dm_rvalid` in 1: read data valid.
- `dm_rdata` in 32: read word.

## Operation
- States: IDLE, REQ, RESP, FIN, ERR.
- **IDLE**
  - If `req_valid` and `mem_rw != MNONE`: latch addr, wdata, rw and whb.
  - Misaligned access goes to ERR. Misaligned means HALF/HALFU with `addr[0]`=1, or WORD with `addr[1:0]`≠0.
  - Otherwise go to REQ. `MNONE` stays in IDLE with no stall.
- **REQ**
  - `dm_req`=1; `dm_addr`, `dm_we` and `dm_wdata` are stable from the latched values.
  - On `dm_gnt`: a WRITE goes to FIN, a READ goes to RESP.
- **RESP**
  - On `dm_rvalid`: load `rd_data` with the extracted, extended value and go to FIN.
  - `dm_rvalid` is ignored outside RESP.
- **FIN**: `done`=1, `stall`=0, then IDLE.
- **ERR**: `misalign` or `bus_err`=1, `stall`=0, then IDLE. No memory access occurs for a misaligned request.
- Store steering (HALFU and BYTEU on writes are treated as HALF and BYTE):
  - BYTE: `wdata[7:0]` replicated to all lanes; `dm_we` = `4'b0001<<addr[1:0]`.
  - HALF: `wdata[15:0]` replicated; `dm_we` = `4'b0011<<{addr[1],1'b0}`.
  - WORD: `dm_we` = `4'hF`.
- Load extraction: byte or half lane selected by `addr[1:0]`; BYTE and HALF sign-extend, BYTEU and HALFU zero-extend, WORD passes through. Any other whb value is treated as WORD.
- `stall` = 1 in IDLE with an accepted request, and throughout REQ and RESP.
- Timeout:
  - An 8-bit-minimum counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - Reaching `TIMEOUT_CYC` goes to ERR with `bus_err`, dropping `dm_req`.
- `rd_data` holds its value until the next successful load. Writes, errors and timeouts leave it unchanged.

## Timing
- Reset values: state IDLE; every output 0, including `rd_data`. `dm_req` drops immediately on `rst_n` low.
- Reset mid-access abandons the request; the memory side must tolerate this.
- Write with `dm_gnt` in the first REQ cycle: accept at c0, REQ at c1, FIN (`done`) at c2.
- Read with `dm_rvalid` one cycle after grant: `done` at c3, with `rd_data` valid from c3 onward.
- The pipeline advances at the end of the FIN or ERR cycle. The next request is sampled in IDLE on the following cycle, so there is at most one access every 3 cycles.
- Simultaneous `dm_gnt` and timeout in the same REQ cycle: grant wins.
- Simultaneous `dm_rvalid` and timeout in RESP: rvalid wins.

## Structure
- Package `lsu_pkg`:
  - State enum.
  - Functions `be_gen(whb, addr_lo)` and `st_steer(whb, wdata)`.
- `MemReWr` and `MemWHB` encodings stay in `parameter_define.sv` and are included, not redefined.
- Sub-module `lsu_load_align`: combinational lane select and sign/zero extension from `dm_rdata`, `addr[1:0]` and `whb`. It is instantiated once and tested standalone.

## Test plan
- SB `wdata`=0x000000A5 at addr 0x103, immediate grant: `dm_we`=4'b1000, `dm_wdata`=0xA5A5A5A5, `dm_addr`=0x100, `done` at c2.
- LB at 0x201, `dm_rdata`=0x12348056, `dm_rvalid` 1 cycle after grant: `rd_data`=0xFFFFFF80. LBU at the same address: 0x00000080.
- LH at 0x002, `dm_rdata`=0x8001_7FFF: `rd_data`=0xFFFF8001. LHU at the same address: 0x00008001.
- LW at 0x006: `misalign` pulse at c1, `dm_req` never asserted, `stall` low at c1, `rd_data` unchanged.
- SW with `dm_gnt` held low and `TIMEOUT_CYC`=4: `bus_err` pulse after 4 REQ cycles, `dm_req` falls, `done` never pulses.
- `rst_n` low during RESP: all outputs 0 asynchronously. After release, a new LW at 0x010 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and store-side helpers for the load/store unit.
package lsu_pkg;
`include "parameter_define.sv"

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RESP,
      FIN,
      ERR
   } lsu_state_e;

   function automatic logic [3:0] be_gen(input logic [2:0] whb, input logic [1:0] addr_lo);
      case (whb)
         BYTE, BYTEU: be_gen = 4'b0001 << addr_lo;
         HALF, HALFU: be_gen = 4'b0011 << {addr_lo[1], 1'b0};
         default:     be_gen = 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] st_steer(input logic [2:0] whb, input logic [31:0] wdata);
      case (whb)
         BYTE, BYTEU: st_steer = {4{wdata[7:0]}};
         HALF, HALFU: st_steer = {2{wdata[15:0]}};
         default:     st_steer = wdata;
      endcase
   endfunction

   // Unknown size codes are held to word alignment, matching how loads treat them.
   function automatic logic is_misaligned(input logic [2:0] whb, input logic [1:0] addr_lo);
      case (whb)
         BYTE, BYTEU: is_misaligned = 1'b0;
         HALF, HALFU: is_misaligned = addr_lo[0];
         default:     is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  whb,
   output logic [31:0] ld_data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (whb)
         BYTE:    ld_data = {{24{byte_sel[7]}}, byte_sel};
         BYTEU:   ld_data = {24'h0, byte_sel};
         HALF:    ld_data = {{16{half_sel[15]}}, half_sel};
         HALFU:   ld_data = {16'h0, half_sel};
         default: ld_data = rdata;
      endcase
   end
endmodule

// File: rtl/parameter_define.sv
// Memory control field encodings shared by the decoder and the memory stage.
`ifndef PARAMETER_DEFINE_SV
`define PARAMETER_DEFINE_SV
localparam logic [1:0] MNONE = 2'b00;
localparam logic [1:0] READ  = 2'b01;
localparam logic [1:0] WRITE = 2'b10;

localparam logic [2:0] WORD  = 3'b000;
localparam logic [2:0] HALF  = 3'b001;
localparam logic [2:0] BYTE  = 3'b010;
localparam logic [2:0] HALFU = 3'b011;
localparam logic [2:0] BYTEU = 3'b100;
`endif

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-addressed access at a time, holding the
// pipeline until completion, misalignment rejection or timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [1:0]  mem_rw,
   input  logic [2:0]  mem_whb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rd_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        dm_req,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata
);
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_e       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic [2:0]       whb_q, whb_d;
   logic             wr_q, wr_d;
   logic             to_q, to_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ld_data;
   logic             accept;
   logic             expired;

   assign accept  = req_valid && (mem_rw != MNONE);
   // The counter may already sit past the limit when a grant won on the last REQ cycle.
   assign expired = (cnt_q >= CNT_LAST);
   assign rd_data = rd_data_q;

   lsu_load_align u_align (
      .rdata   (dm_rdata),
      .addr_lo (addr_q[1:0]),
      .whb     (whb_q),
      .ld_data (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         whb_q     <= '0;
         wr_q      <= 1'b0;
         to_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         whb_q     <= whb_d;
         wr_q      <= wr_d;
         to_q      <= to_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      whb_d     = whb_q;
      wr_d      = wr_q;
      to_d      = to_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = addr;
               wdata_d = wdata;
               whb_d   = mem_whb;
               wr_d    = (mem_rw == WRITE);
               to_d    = 1'b0;
               cnt_d   = '0;
               state_d = is_misaligned(mem_whb, addr[1:0]) ? ERR : REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dm_gnt) begin
               state_d = wr_q ? FIN : RESP;
            end else if (expired) begin
               state_d = ERR;
               to_d    = 1'b1;
            end
         end
         RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dm_rvalid) begin
               rd_data_d = ld_data;
               state_d   = FIN;
            end else if (expired) begin
               state_d = ERR;
               to_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      done     = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
      dm_req   = 1'b0;
      dm_addr  = '0;
      dm_we    = '0;
      dm_wdata = '0;
      case (state_q)
         IDLE: stall = accept && rst_n;
         REQ: begin
            stall   = 1'b1;
            dm_req  = 1'b1;
            dm_addr = {addr_q[31:2], 2'b00};
            if (wr_q) begin
               dm_we    = be_gen(whb_q, addr_q[1:0]);
               dm_wdata = st_steer(whb_q, wdata_q);
            end
         end
         RESP: stall = 1'b1;
         FIN:  done = 1'b1;
         ERR: begin
            misalign = !to_q;
            bus_err  = to_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: standalone lane-align vectors, scoreboarded accesses,
// timeout races and a reset taken in the middle of a read.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int TO = 4;
   localparam logic [1:0] K_DONE = 2'd1;
   localparam logic [1:0] K_MIS  = 2'd2;
   localparam logic [1:0] K_BERR = 2'd3;

   logic        clk, rst_n;
   logic        req_valid;
   logic [1:0]  mem_rw;
   logic [2:0]  mem_whb;
   logic [31:0] addr, wdata;
   logic        stall, done, misalign, bus_err, dm_req;
   logic [31:0] rd_data, dm_addr, dm_wdata;
   logic [3:0]  dm_we;
   logic        dm_gnt, dm_rvalid;
   logic [31:0] dm_rdata;

   logic [31:0] al_rdata, al_out;
   logic [1:0]  al_lo;
   logic [2:0]  al_whb;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd;
   logic [33:0] exp_q[$];
   logic [33:0] mon_exp;
   logic [1:0]  mon_kind;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  lo;
      logic [2:0]  whb;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[14];

   load_store_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_rw(mem_rw),
      .mem_whb(mem_whb), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rd_data(rd_data), .misalign(misalign), .bus_err(bus_err), .dm_req(dm_req),
      .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
   );

   lsu_load_align u_al (.rdata(al_rdata), .addr_lo(al_lo), .whb(al_whb), .ld_data(al_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [2:0] whb, input logic [1:0] lo,
                                             input logic [31:0] w);
      logic [31:0] b, h;
      b = w >> (int'(lo) * 8);
      h = lo[1] ? (w >> 16) : w;
      case (whb)
         BYTE:    return {{24{b[7]}}, b[7:0]};
         BYTEU:   return {24'h0, b[7:0]};
         HALF:    return {{16{h[15]}}, h[15:0]};
         HALFU:   return {16'h0, h[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic mis_model(input logic [2:0] whb, input logic [1:0] lo);
      if (whb == BYTE || whb == BYTEU) return 1'b0;
      if (whb == HALF || whb == HALFU) return lo[0];
      return lo != 2'b00;
   endfunction

   // Completion monitor: every done/misalign/bus_err pulse pops one expectation.
   always @(negedge clk) begin
      if (rst_n && (done || misalign || bus_err)) begin
         chk("event_onehot", 64'(int'(done) + int'(misalign) + int'(bus_err)), 64'd1);
         chk("event_stall", 64'(stall), 64'd0);
         mon_kind = done ? K_DONE : (misalign ? K_MIS : K_BERR);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(mon_kind), 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("event_kind", 64'(mon_kind), 64'(mon_exp[33:32]));
            chk("rd_data", 64'(rd_data), 64'(mon_exp[31:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [1:0] rw, input logic [2:0] whb, input logic [31:0] a,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdat);
      logic [1:0]  kind;
      logic [31:0] exp_rd, exp_wd;
      logic [3:0]  exp_we;
      int exp_cyc, exp_rq, g, lim, cyc, rq, rs;
      bit fin, granted;
      exp_rd = last_rd;
      exp_rq = 0;
      if (mis_model(whb, a[1:0])) begin
         kind = K_MIS; exp_cyc = 1;
      end else if (gnt_dly >= TO) begin
         kind = K_BERR; exp_cyc = 1 + TO; exp_rq = TO;
      end else begin
         g = gnt_dly + 1;
         exp_rq = g;
         if (rw == WRITE) begin
            kind = K_DONE; exp_cyc = 1 + g;
         end else begin
            lim = (TO - g > 1) ? TO - g : 1;
            if (rv_dly + 1 <= lim) begin
               kind = K_DONE; exp_cyc = 1 + g + rv_dly + 1;
               exp_rd = ext_model(whb, a[1:0], rdat);
            end else begin
               kind = K_BERR; exp_cyc = 1 + g + lim;
            end
         end
      end
      if (whb == BYTE || whb == BYTEU) begin
         exp_we = 4'b0001 << a[1:0]; exp_wd = {4{wd[7:0]}};
      end else if (whb == HALF || whb == HALFU) begin
         exp_we = a[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wd[15:0]}};
      end else begin
         exp_we = 4'hF; exp_wd = wd;
      end
      if (rw != WRITE) exp_we = 4'h0;
      last_rd = exp_rd;
      exp_q.push_back({kind, exp_rd});

      tick();
      req_valid = 1'b1; mem_rw = rw; mem_whb = whb; addr = a; wdata = wd;
      #1 chk("c0_stall", 64'(stall), 64'd1);
      tick();
      req_valid = 1'b0; mem_rw = MNONE;
      mem_whb = 3'($urandom); addr = $urandom; wdata = $urandom;
      fin = 0; cyc = 1; rq = 0; rs = 0; granted = 0;
      while (!fin && cyc < 40) begin
         dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
         if (done || misalign || bus_err) begin
            fin = 1;
         end else if (dm_req) begin
            if (rq == 0) begin
               chk("dm_addr", 64'(dm_addr), 64'({a[31:2], 2'b00}));
               chk("dm_we", 64'(dm_we), 64'(exp_we));
               if (rw == WRITE) chk("dm_wdata", 64'(dm_wdata), 64'(exp_wd));
            end
            if (rq == gnt_dly) begin
               dm_gnt = 1'b1; granted = 1;
            end else begin
               dm_rvalid = 1'($urandom_range(0, 1));
            end
            rq++;
         end else if (granted) begin
            if (rs == rv_dly) begin
               dm_rvalid = 1'b1; dm_rdata = rdat;
            end
            rs++;
         end
         if (!fin) begin
            tick();
            cyc++;
         end
      end
      dm_gnt = 1'b0; dm_rvalid = 1'b0;
      chk("access_bound", 64'(fin), 64'd1);
      chk("finish_cycle", 64'(cyc), 64'(exp_cyc));
      chk("req_cycles", 64'(rq), 64'(exp_rq));
   endtask

   initial begin
      logic [1:0]  rw;
      logic [2:0]  w;
      logic [31:0] a;

      vecs[0]  = '{32'h12348056, 2'd1, BYTE,  32'hFFFFFF80};
      vecs[1]  = '{32'h12348056, 2'd1, BYTEU, 32'h00000080};
      vecs[2]  = '{32'h12348056, 2'd0, BYTE,  32'h00000056};
      vecs[3]  = '{32'h12348056, 2'd3, BYTE,  32'h00000012};
      vecs[4]  = '{32'h12348056, 2'd2, BYTE,  32'h00000034};
      vecs[5]  = '{32'h80017FFF, 2'd2, HALF,  32'hFFFF8001};
      vecs[6]  = '{32'h80017FFF, 2'd2, HALFU, 32'h00008001};
      vecs[7]  = '{32'h80017FFF, 2'd0, HALF,  32'h00007FFF};
      vecs[8]  = '{32'hF00DBEEF, 2'd0, HALF,  32'hFFFFBEEF};
      vecs[9]  = '{32'hF00DBEEF, 2'd0, WORD,  32'hF00DBEEF};
      vecs[10] = '{32'hF00DBEEF, 2'd0, 3'b111, 32'hF00DBEEF};
      vecs[11] = '{32'hF00DBEEF, 2'd3, BYTEU, 32'h000000F0};
      vecs[12] = '{32'hF00DBEEF, 2'd3, BYTE,  32'hFFFFFFF0};
      vecs[13] = '{32'hF00DBEEF, 2'd2, HALFU, 32'h0000F00D};

      rst_n = 1'b0; req_valid = 1'b0; mem_rw = MNONE; mem_whb = WORD;
      addr = '0; wdata = '0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
      last_rd = '0;

      for (int i = 0; i < 14; i++) begin
         al_rdata = vecs[i].rdata; al_lo = vecs[i].lo; al_whb = vecs[i].whb;
         #1 chk($sformatf("align_%0d", i), 64'(al_out), 64'(vecs[i].exp));
      end

      #12;
      chk("reset_ctrl", 64'({stall, done, misalign, bus_err, dm_req, dm_we}), 64'd0);
      chk("reset_data", 64'({rd_data, dm_addr}), 64'd0);
      chk("reset_wdata", 64'(dm_wdata), 64'd0);
      rst_n = 1'b1;

      // Directed accesses: (rw, whb, addr, wdata, grant delay, rvalid delay, read word)
      access(WRITE, BYTE,  32'h103, 32'h000000A5, 0, 0, 32'h0);
      access(READ,  BYTE,  32'h201, 32'h0, 0, 0, 32'h12348056);
      access(READ,  BYTEU, 32'h201, 32'h0, 0, 0, 32'h12348056);
      access(READ,  HALF,  32'h002, 32'h0, 0, 0, 32'h80017FFF);
      access(READ,  HALFU, 32'h002, 32'h0, 0, 0, 32'h80017FFF);
      access(READ,  WORD,  32'h006, 32'h0, 0, 0, 32'hDEADBEEF);
      access(WRITE, WORD,  32'h040, 32'h11223344, 99, 0, 32'h0);
      access(WRITE, HALF,  32'h002, 32'h1234BEEF, 2, 0, 32'h0);
      access(WRITE, HALFU, 32'h003, 32'h1234BEEF, 0, 0, 32'h0);
      access(READ,  HALF,  32'h001, 32'h0, 0, 0, 32'h0);
      access(READ,  WORD,  32'h020, 32'h0, 1, 1, 32'hA5A55A5A);
      access(READ,  BYTE,  32'h022, 32'h0, 3, 0, 32'h00C30000);
      access(READ,  WORD,  32'h024, 32'h0, 3, 1, 32'h77777777);
      access(READ,  WORD,  32'h028, 32'h0, 0, 99, 32'h66666666);
      access(WRITE, WORD,  32'h02C, 32'h01020304, 3, 0, 32'h0);
      access(WRITE, BYTEU, 32'h032, 32'h0000007E, 1, 0, 32'h0);

      for (int i = 0; i < 24; i++) begin
         rw = $urandom_range(0, 1) ? WRITE : READ;
         case ($urandom_range(0, 4))
            0:       w = WORD;
            1:       w = HALF;
            2:       w = BYTE;
            3:       w = HALFU;
            default: w = BYTEU;
         endcase
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = (w == WORD) ? 2'b00 : {a[1], 1'b0};
         access(rw, w, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
      end

      // MNONE must neither stall nor start an access.
      tick();
      req_valid = 1'b1; mem_rw = MNONE; mem_whb = WORD; addr = 32'h80;
      #1 chk("mnone_stall", 64'(stall), 64'd0);
      tick();
      chk("mnone_no_req", 64'({dm_req, stall}), 64'd0);
      req_valid = 1'b0;

      access(READ, WORD, 32'h0C0, 32'h0, 0, 0, 32'hCAFEF00D);

      // Reset while waiting for read data.
      tick();
      req_valid = 1'b1; mem_rw = READ; mem_whb = WORD; addr = 32'h040;
      tick();
      req_valid = 1'b0; mem_rw = MNONE;
      chk("rst_seq_req", 64'(dm_req), 64'd1);
      dm_gnt = 1'b1;
      tick();
      dm_gnt = 1'b0;
      chk("rst_seq_resp_stall", 64'({stall, rd_data}), 64'({1'b1, 32'hCAFEF00D}));
      rst_n = 1'b0;
      #1;
      chk("rst_async_ctrl", 64'({stall, done, misalign, bus_err, dm_req, dm_we}), 64'd0);
      chk("rst_async_data", 64'({rd_data, dm_addr}), 64'd0);
      chk("rst_async_wdata", 64'(dm_wdata), 64'd0);
      last_rd = '0;
      #2 rst_n = 1'b1;

      access(READ, WORD, 32'h010, 32'h0, 0, 0, 32'h0BADC0DE);

      tick();
      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
